// File: rtl/spine_pkg.sv
// Shared definitions for the spine-side leaf port termination.
// Holds the reference flit width, the destination field width, a helper
// that extracts the destination address from a reference-width flit, and
// the state type for the egress (crossbar-to-leaf) pacing FSM.
package spine_pkg;

  localparam int FLIT_W = 16;
  localparam int DEST_W = 6;

  // Destination address lives in the top DEST_W bits of every flit
  function automatic logic [DEST_W-1:0] dest_of(input logic [FLIT_W-1:0] flit);
    return flit[FLIT_W-1 -: DEST_W];
  endfunction

  typedef enum logic {
    TX_IDLE = 1'b0,
    TX_GAP  = 1'b1
  } tx_state_t;

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through synchronous FIFO.
// Ports:
//   clk, reset      clock and asynchronous active-high reset
//   push_i, wdata_i write strobe and data (caller guarantees no push while
//                   full unless a pop happens in the same cycle)
//   pop_i           read strobe (caller guarantees not empty)
//   rdata_o         head entry, valid whenever empty_o is low
//   full_o, empty_o occupancy flags
//   level_o         number of stored entries (0..DEPTH)
module sync_fifo_fwft #(
  parameter int DWIDTH = 16,
  parameter int DEPTH  = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push_i,
  input  logic [DWIDTH-1:0] wdata_i,
  input  logic              pop_i,
  output logic [DWIDTH-1:0] rdata_o,
  output logic              full_o,
  output logic              empty_o,
  output logic [AW:0]       level_o
);

  logic [DWIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]       wr_ptr_q;
  logic [AW:0]       rd_ptr_q;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  // Storage is cleared on reset so the head output reads zero out of reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
        wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      end
      if (pop_i) begin
        rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
      end
    end
  end

  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign level_o = wr_ptr_q - rd_ptr_q;

endmodule

// File: rtl/spine_leaf_port.sv
// Spine-side termination of one leaf-router spine link.
// Ingress: flits from the leaf's spine output (no backpressure) go into a
// drop-on-full FWFT FIFO and are offered to the crossbar with valid/ready.
// Egress: crossbar flits are registered and driven to the leaf's spine input
// as one-cycle pulses, with the destination decoded and optional pacing.
// Ports:
//   clk, reset                      clock, asynchronous active-high reset
//   leaf_out_data/valid             flit from router spine output
//   up_data/valid/ready             FIFO head toward crossbar
//   dn_data/valid/ready             flit from crossbar
//   leaf_in_data/valid/dest_addr    flit pulse to router spine input
//   rx_level                        FIFO occupancy
//   drop_count                      saturating count of dropped flits
module spine_leaf_port
  import spine_pkg::*;
#(
  parameter int DWIDTH = 16,
  parameter int DEPTH  = 8,
  parameter int TX_GAP = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [DWIDTH-1:0]        leaf_out_data,
  input  logic                     leaf_out_valid,
  output logic [DWIDTH-1:0]        up_data,
  output logic                     up_valid,
  input  logic                     up_ready,
  input  logic [DWIDTH-1:0]        dn_data,
  input  logic                     dn_valid,
  output logic                     dn_ready,
  output logic [DWIDTH-1:0]        leaf_in_data,
  output logic                     leaf_in_valid,
  output logic [DEST_W-1:0]        leaf_in_dest_addr,
  output logic [$clog2(DEPTH):0]   rx_level,
  output logic [7:0]               drop_count
);

  // ---------------- Ingress ----------------
  logic full;
  logic empty;
  logic push;
  logic pop;
  logic drop;
  logic [7:0] drop_count_q;

  // A pop in the same cycle frees the slot, so a full FIFO can still accept
  assign pop  = !empty && up_ready;
  assign push = leaf_out_valid && (!full || pop);
  assign drop = leaf_out_valid && full && !pop;

  sync_fifo_fwft #(
    .DWIDTH(DWIDTH),
    .DEPTH (DEPTH)
  ) u_rx_fifo (
    .clk    (clk),
    .reset  (reset),
    .push_i (push),
    .wdata_i(leaf_out_data),
    .pop_i  (pop),
    .rdata_o(up_data),
    .full_o (full),
    .empty_o(empty),
    .level_o(rx_level)
  );

  assign up_valid = !empty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drop_count_q <= '0;
    end else if (drop && drop_count_q != 8'hFF) begin
      drop_count_q <= drop_count_q + 8'd1;
    end
  end

  assign drop_count = drop_count_q;

  // ---------------- Egress ----------------
  // The parameter TX_GAP shadows the enum literal, so the state is scoped.
  tx_state_t           state_q, state_d;
  logic [3:0]          gap_cnt_q, gap_cnt_d;
  logic [DWIDTH-1:0]   data_q, data_d;
  logic [DEST_W-1:0]   dest_q, dest_d;
  logic                valid_q, valid_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= TX_IDLE;
      gap_cnt_q <= '0;
      data_q    <= '0;
      dest_q    <= '0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      gap_cnt_q <= gap_cnt_d;
      data_q    <= data_d;
      dest_q    <= dest_d;
      valid_q   <= valid_d;
    end
  end

  // dn_ready comes from state alone; data/dest hold between pulses
  always_comb begin
    state_d   = state_q;
    gap_cnt_d = gap_cnt_q;
    data_d    = data_q;
    dest_d    = dest_q;
    valid_d   = 1'b0;
    dn_ready  = 1'b0;
    case (state_q)
      TX_IDLE: begin
        dn_ready = 1'b1;
        if (dn_valid) begin
          data_d  = dn_data;
          dest_d  = dn_data[DWIDTH-1 -: DEST_W];
          valid_d = 1'b1;
          if (TX_GAP > 0) begin
            state_d   = spine_pkg::TX_GAP;
            gap_cnt_d = 4'(TX_GAP);
          end
        end
      end
      spine_pkg::TX_GAP: begin
        gap_cnt_d = gap_cnt_q - 4'd1;
        if (gap_cnt_q == 4'd1) begin
          state_d = TX_IDLE;
        end
      end
      default: begin
        state_d = TX_IDLE;
      end
    endcase
  end

  assign leaf_in_data      = data_q;
  assign leaf_in_dest_addr = dest_q;
  assign leaf_in_valid     = valid_q;

endmodule

// File: tb/tb_spine_leaf_port.sv
// Directed self-checking bench for spine_leaf_port.
// Two instances share all inputs: dut0 with TX_GAP=0 and dut3 with TX_GAP=3.
module tb_spine_leaf_port;

  logic        clk;
  logic        reset;
  logic [15:0] leaf_out_data;
  logic        leaf_out_valid;
  logic        up_ready;
  logic [15:0] dn_data;
  logic        dn_valid;

  logic [15:0] up_data0, up_data3;
  logic        up_valid0, up_valid3;
  logic        dn_ready0, dn_ready3;
  logic [15:0] leaf_in_data0, leaf_in_data3;
  logic        leaf_in_valid0, leaf_in_valid3;
  logic [5:0]  dest0, dest3;
  logic [3:0]  rx_level0, rx_level3;
  logic [7:0]  drop0, drop3;

  int testCount = 0;
  int failCount = 0;

  spine_leaf_port #(.DWIDTH(16), .DEPTH(8), .TX_GAP(0)) dut0 (
    .clk(clk), .reset(reset),
    .leaf_out_data(leaf_out_data), .leaf_out_valid(leaf_out_valid),
    .up_data(up_data0), .up_valid(up_valid0), .up_ready(up_ready),
    .dn_data(dn_data), .dn_valid(dn_valid), .dn_ready(dn_ready0),
    .leaf_in_data(leaf_in_data0), .leaf_in_valid(leaf_in_valid0),
    .leaf_in_dest_addr(dest0), .rx_level(rx_level0), .drop_count(drop0)
  );

  spine_leaf_port #(.DWIDTH(16), .DEPTH(8), .TX_GAP(3)) dut3 (
    .clk(clk), .reset(reset),
    .leaf_out_data(leaf_out_data), .leaf_out_valid(leaf_out_valid),
    .up_data(up_data3), .up_valid(up_valid3), .up_ready(up_ready),
    .dn_data(dn_data), .dn_valid(dn_valid), .dn_ready(dn_ready3),
    .leaf_in_data(leaf_in_data3), .leaf_in_valid(leaf_in_valid3),
    .leaf_in_dest_addr(dest3), .rx_level(rx_level3), .drop_count(drop3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts and reports mismatches
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Advance one clock with the current inputs and settle just past the edge
  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  task automatic pulseReset();
    reset = 1'b1;
    applyStimulus();
    reset = 1'b0;
  endtask

  logic [15:0] drainExp [8];
  logic [15:0] gapFlits [4];

  initial begin
    reset          = 1'b1;
    leaf_out_data  = '0;
    leaf_out_valid = 1'b0;
    up_ready       = 1'b0;
    dn_data        = '0;
    dn_valid       = 1'b0;

    // Reset values
    applyStimulus();
    checkOutput("rst_leaf_in_data", 32'(leaf_in_data0), 32'h0);
    checkOutput("rst_dest", 32'(dest0), 32'h0);
    checkOutput("rst_leaf_in_valid", 32'(leaf_in_valid0), 32'h0);
    checkOutput("rst_dn_ready", 32'(dn_ready0), 32'h1);
    checkOutput("rst_up_valid", 32'(up_valid0), 32'h0);
    checkOutput("rst_up_data", 32'(up_data0), 32'h0);
    checkOutput("rst_rx_level", 32'(rx_level0), 32'h0);
    checkOutput("rst_drop", 32'(drop0), 32'h0);
    reset = 1'b0;
    applyStimulus();

    // Single ingress flit, popped one cycle after it appears
    leaf_out_data  = 16'h2C01;
    leaf_out_valid = 1'b1;
    up_ready       = 1'b1;
    applyStimulus();
    leaf_out_valid = 1'b0;
    checkOutput("ing_up_valid", 32'(up_valid0), 32'h1);
    checkOutput("ing_up_data", 32'(up_data0), 32'h2C01);
    checkOutput("ing_level1", 32'(rx_level0), 32'h1);
    applyStimulus();
    checkOutput("ing_level0", 32'(rx_level0), 32'h0);
    checkOutput("ing_empty", 32'(up_valid0), 32'h0);

    // Ten flits into an 8-deep FIFO with no reader: two dropped
    up_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      leaf_out_data  = 16'(i);
      leaf_out_valid = 1'b1;
      applyStimulus();
    end
    leaf_out_valid = 1'b0;
    checkOutput("fill_level", 32'(rx_level0), 32'h8);
    checkOutput("fill_drop", 32'(drop0), 32'h2);
    checkOutput("fill_head", 32'(up_data0), 32'h0);

    // Full with a simultaneous pop and push: no drop, level unchanged
    leaf_out_data  = 16'h00AA;
    leaf_out_valid = 1'b1;
    up_ready       = 1'b1;
    applyStimulus();
    leaf_out_valid = 1'b0;
    checkOutput("fullpp_level", 32'(rx_level0), 32'h8);
    checkOutput("fullpp_drop", 32'(drop0), 32'h2);

    // Drain in order: 1..7 then the late 0xAA
    for (int k = 0; k < 7; k++) drainExp[k] = 16'(k + 1);
    drainExp[7] = 16'h00AA;
    for (int k = 0; k < 8; k++) begin
      checkOutput($sformatf("drain_%0d", k), 32'(up_data0), 32'(drainExp[k]));
      applyStimulus();
    end
    checkOutput("drain_level", 32'(rx_level0), 32'h0);
    checkOutput("drain_valid", 32'(up_valid0), 32'h0);
    up_ready = 1'b0;

    // TX_GAP=0: back-to-back egress flits
    pulseReset();
    dn_data  = 16'hFC00;
    dn_valid = 1'b1;
    checkOutput("b2b_ready0", 32'(dn_ready0), 32'h1);
    applyStimulus();
    checkOutput("b2b_valid_a", 32'(leaf_in_valid0), 32'h1);
    checkOutput("b2b_dest_a", 32'(dest0), 32'h3F);
    checkOutput("b2b_data_a", 32'(leaf_in_data0), 32'hFC00);
    checkOutput("b2b_ready1", 32'(dn_ready0), 32'h1);
    dn_data = 16'h0401;
    applyStimulus();
    dn_valid = 1'b0;
    checkOutput("b2b_valid_b", 32'(leaf_in_valid0), 32'h1);
    checkOutput("b2b_dest_b", 32'(dest0), 32'h01);
    checkOutput("b2b_ready2", 32'(dn_ready0), 32'h1);
    applyStimulus();
    checkOutput("b2b_valid_end", 32'(leaf_in_valid0), 32'h0);
    checkOutput("b2b_data_hold", 32'(leaf_in_data0), 32'h0401);

    // TX_GAP=3: dn_valid held, accepts every 4th cycle
    pulseReset();
    gapFlits[0] = 16'h0401;
    gapFlits[1] = 16'h0802;
    gapFlits[2] = 16'h0C03;
    gapFlits[3] = 16'h1004;
    dn_valid = 1'b1;
    for (int c = 0; c < 16; c++) begin
      dn_data = gapFlits[c / 4];
      checkOutput($sformatf("gap_ready_%0d", c), 32'(dn_ready3),
                  (c % 4 == 0) ? 32'h1 : 32'h0);
      applyStimulus();
      checkOutput($sformatf("gap_valid_%0d", c), 32'(leaf_in_valid3),
                  (c % 4 == 0) ? 32'h1 : 32'h0);
      if (c % 4 == 0) begin
        checkOutput($sformatf("gap_data_%0d", c), 32'(leaf_in_data3),
                    32'(gapFlits[c / 4]));
      end
    end
    dn_valid = 1'b0;
    applyStimulus();
    checkOutput("gap_ready_end", 32'(dn_ready3), 32'h1);

    // Reset in GAP with 5 entries buffered
    pulseReset();
    up_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      leaf_out_data  = 16'(i + 16'h10);
      leaf_out_valid = 1'b1;
      if (i == 4) begin
        dn_data  = 16'h0C00;
        dn_valid = 1'b1;
      end
      applyStimulus();
    end
    leaf_out_valid = 1'b0;
    dn_valid       = 1'b0;
    checkOutput("pre_rst_level", 32'(rx_level3), 32'h5);
    checkOutput("pre_rst_ready", 32'(dn_ready3), 32'h0);
    checkOutput("pre_rst_valid", 32'(leaf_in_valid3), 32'h1);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("async_valid", 32'(leaf_in_valid3), 32'h0);
    checkOutput("async_up_valid", 32'(up_valid3), 32'h0);
    checkOutput("async_ready", 32'(dn_ready3), 32'h1);
    checkOutput("async_level", 32'(rx_level3), 32'h0);
    #1;
    reset = 1'b0;

    // 8 fills then 300 drops: counter saturates
    leaf_out_valid = 1'b1;
    for (int i = 0; i < 308; i++) begin
      leaf_out_data = 16'(i);
      applyStimulus();
    end
    leaf_out_valid = 1'b0;
    checkOutput("sat_drop0", 32'(drop0), 32'hFF);
    checkOutput("sat_drop3", 32'(drop3), 32'hFF);
    checkOutput("sat_level", 32'(rx_level0), 32'h8);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
